// File: rtl/dff_pipe_pkg.sv
// Shared constants, occupancy-width helper and the default stage record for dff_pipe_chain.
// Optional parity storage is enabled with the DFF_PIPE_PARITY_EN macro.
package dff_pipe_pkg;

    localparam int DFF_PIPE_DEF_WIDTH = 8;
    localparam int DFF_PIPE_DEF_DEPTH = 4;

`ifdef DFF_PIPE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Default-width stage record; the cell declares its own width-generic copy.
    typedef struct packed {
        logic                                    valid;
        logic [DFF_PIPE_DEF_WIDTH+PAR_BITS-1:0]  word;
    } stage_t;

endpackage

// File: rtl/dff_pipe_chain_if.sv
// Producer/consumer handshake bundle for dff_pipe_chain.
// out_parity_err exists only when DFF_PIPE_PARITY_EN is defined.
interface dff_pipe_chain_if
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_DEF_WIDTH,
    parameter int DEPTH = DFF_PIPE_DEF_DEPTH
);
    localparam int OCC_W = occ_width(DEPTH);

    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [OCC_W-1:0] occupancy;
`ifdef DFF_PIPE_PARITY_EN
    logic             out_parity_err;
`endif

    modport master (
        output flush, in_valid, in_data, out_ready,
`ifdef DFF_PIPE_PARITY_EN
        input  out_parity_err,
`endif
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
`ifdef DFF_PIPE_PARITY_EN
        output out_parity_err,
`endif
        output in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/dff_pipe_chain_cell.sv
// One pipeline stage: valid flag plus stored word, loaded from upstream or held.
// clr drops the valid flag and blocks any load in the same cycle.
module dff_pipe_cell
    import dff_pipe_pkg::*;
#(
    parameter int SW = DFF_PIPE_DEF_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          load,
    input  logic          move,
    input  logic [SW-1:0] d,
    output logic          valid,
    output logic [SW-1:0] q
);
    typedef struct packed {
        logic          valid;
        logic [SW-1:0] word;
    } cell_t;

    cell_t stage_reg;
    cell_t stage_next;

    always_comb begin
        stage_next = stage_reg;
        if (clr) begin
            stage_next.valid = 1'b0;
        end else begin
            stage_next.valid = load | (stage_reg.valid & ~move);
            if (load) begin
                stage_next.word = d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign valid = stage_reg.valid;
    assign q     = stage_reg.word;

endmodule

// File: rtl/dff_pipe_chain.sv
// Elastic DEPTH-stage register chain with valid/ready back-pressure, flush and occupancy.
// Define DFF_PIPE_PARITY_EN to carry a per-word parity bit and a sticky out_parity_err flag.
module dff_pipe_chain
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_DEF_WIDTH,
    parameter int DEPTH = DFF_PIPE_DEF_DEPTH
) (
    input logic             clk,
    input logic             reset,
    dff_pipe_chain_if.slave bus
);
    localparam int SW    = WIDTH + PAR_BITS;
    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] move;
    logic [DEPTH-1:0] load;
    logic [SW-1:0]    word [DEPTH];
    logic [SW-1:0]    in_word;
    logic             in_ready_int;
    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;

`ifdef DFF_PIPE_PARITY_EN
    assign in_word = {^bus.in_data, bus.in_data};
`else
    assign in_word = bus.in_data;
`endif

    // Walk from the output back to the input so each stage sees whether its successor frees up.
    always_comb begin
        logic free;
        free = bus.out_ready;
        move = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            move[i] = valid[i] & free;
            free    = ~valid[i] | move[i];
        end
        in_ready_int = free;
    end

    assign in_xfer  = bus.in_valid & in_ready_int;
    assign out_xfer = move[DEPTH-1];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [SW-1:0] d_word;
            if (gi == 0) begin : g_head
                assign load[gi] = in_xfer;
                assign d_word   = in_word;
            end else begin : g_body
                assign load[gi] = move[gi-1];
                assign d_word   = word[gi-1];
            end

            dff_pipe_cell #(.SW(SW)) u_cell (
                .clk   (clk),
                .reset (reset),
                .clr   (bus.flush),
                .load  (load[gi]),
                .move  (move[gi]),
                .d     (d_word),
                .valid (valid[gi]),
                .q     (word[gi])
            );
        end
    endgenerate

    always_comb begin
        occ_next = occ_reg;
        if (bus.flush) begin
            occ_next = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_next = occ_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

`ifdef DFF_PIPE_PARITY_EN
    logic perr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_reg <= 1'b0;
        end else if (bus.flush) begin
            perr_reg <= 1'b0;
        end else if (out_xfer && ((^word[DEPTH-1][WIDTH-1:0]) != word[DEPTH-1][WIDTH])) begin
            perr_reg <= 1'b1;
        end
    end

    assign bus.out_parity_err = perr_reg;
`endif

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = valid[DEPTH-1];
    assign bus.out_data  = word[DEPTH-1][WIDTH-1:0];
    assign bus.occupancy = occ_reg;

endmodule
